id_ex_latch: RTL
================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameter NB_DATA, default 32, width of data, PC and immediate fields.
REQ-002 Parameter NB_REG, default 5, register-address width.
REQ-003 Parameter NB_CTRL, default 8, control-bundle width.
REQ-004 Parameter NB_COUNT, default 16, stall-counter width.
REQ-005 i_clock  in  1  single clock; all state updates on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_enable  in  1  debug-unit step enable; low freezes all state.
REQ-008 i_flush  in  1  taken branch/jump; converts the ID-stage instruction to a bubble.
REQ-009 i_valid  in  1  ID stage holds a real instruction.
REQ-010 i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext  in  NB_DATA each  PC+4, register-file reads, sign-extended immediate.
REQ-011 i_rs, i_rt, i_rd  in  NB_REG each  decoded register addresses.
REQ-012 i_ctrl  in  NB_CTRL  bits [0]reg_write [1]mem_to_reg [2]mem_read [3]mem_write [4]alu_src [5]reg_dst [7:6]alu_op.
REQ-013 o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext  out  NB_DATA  registered copies for EX.
REQ-014 o_rs, o_rt, o_rd  out  NB_REG  registered addresses.
REQ-015 o_ctrl  out  NB_CTRL  registered control bundle.
REQ-016 o_valid  out  1  EX holds a real instruction.
REQ-017 o_stall  out  1  load-use hazard; upstream PC and IF/ID SHALL hold.
REQ-018 o_stall_count  out  NB_COUNT  number of hazard bubbles inserted.

Function
REQ-019 Hazard: o_stall = o_valid & o_ctrl[2] & (o_rt != 0) & i_valid & (o_rt == i_rs | o_rt == i_rt), combinational from registered state and inputs, independent of i_enable.
REQ-020 Per-edge priority: reset > i_enable low > i_flush > o_stall > normal load.
REQ-021 i_enable low: every register, including o_stall_count, holds its value.
REQ-022 Normal load (enable, no flush, no stall): all o_* fields capture their i_* counterparts; o_valid <= i_valid; latency exactly one cycle.
REQ-023 Bubble (flush or stall): data and address fields capture inputs; o_ctrl <= 0; o_valid <= 0.
REQ-024 i_valid low with normal load: o_ctrl SHALL load as 0 regardless of i_ctrl.
REQ-025 Flush and stall together: single bubble; o_stall_count not incremented.
REQ-026 o_stall_count increments by 1 on each enabled edge where a stall bubble (not flush) is inserted; saturates at 2^NB_COUNT-1, no wrap.
REQ-027 After a stall bubble, o_ctrl[2]=0, so o_stall deasserts next cycle; a load-use pair stalls exactly one cycle.
REQ-028 Register 0 as o_rt never causes a stall.
REQ-029 o_stall SHALL be asserted while i_enable is low if the hazard condition holds; no state changes.

Reset
REQ-030 i_reset high asynchronously clears all outputs to 0, o_stall_count to 0, o_valid to 0; o_stall reads 0 during reset.
REQ-031 Reset asserted mid-stall discards the pending instruction; the first enabled edge after release performs a normal load.
REQ-032 Reset deassertion takes effect at the next rising edge; no register changes while reset is high.

Verification
REQ-033 Normal: i_valid=1, i_ctrl=0x31, i_imm_ext=0xFFFFFFF0, i_rt=9, enable -> next cycle o_ctrl=0x31, o_imm_ext=0xFFFFFFF0, o_rt=9, o_valid=1, o_stall=0.
REQ-034 Load-use: EX holds lw (o_ctrl=0x17, o_rt=8); ID i_rs=8, i_valid=1 -> o_stall=1 same cycle; next edge o_ctrl=0, o_valid=0, o_stall_count=1; following cycle o_stall=0.
REQ-035 Flush+stall: same as REQ-034 plus i_flush=1 -> o_ctrl=0, o_valid=0, o_stall_count unchanged (0).
REQ-036 Freeze: i_enable=0 for 3 cycles with changing inputs -> all outputs constant; hazard present -> o_stall=1 throughout.
REQ-037 Saturation: NB_COUNT=4, force 17 consecutive stall bubbles -> o_stall_count stops at 15.
REQ-038 Async reset: assert i_reset between edges with o_valid=1 -> all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for the EX stage. It turns the ID
// instruction into a bubble on a flush or on a load-use stall. It also
// counts the stall bubbles it inserts, and that count saturates.
module id_ex_latch #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_CTRL  = 8,
    parameter int NB_COUNT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_pc_plus4,
    input  logic [NB_DATA-1:0]  i_rs_data,
    input  logic [NB_DATA-1:0]  i_rt_data,
    input  logic [NB_DATA-1:0]  i_imm_ext,
    input  logic [NB_REG-1:0]   i_rs,
    input  logic [NB_REG-1:0]   i_rt,
    input  logic [NB_REG-1:0]   i_rd,
    input  logic [NB_CTRL-1:0]  i_ctrl,
    output logic [NB_DATA-1:0]  o_pc_plus4,
    output logic [NB_DATA-1:0]  o_rs_data,
    output logic [NB_DATA-1:0]  o_rt_data,
    output logic [NB_DATA-1:0]  o_imm_ext,
    output logic [NB_REG-1:0]   o_rs,
    output logic [NB_REG-1:0]   o_rt,
    output logic [NB_REG-1:0]   o_rd,
    output logic [NB_CTRL-1:0]  o_ctrl,
    output logic                o_valid,
    output logic                o_stall,
    output logic [NB_COUNT-1:0] o_stall_count
);

    // Bit position of mem_read inside the control bundle.
    localparam int CTRL_MEM_READ = 2;

    logic [NB_DATA-1:0]  pc_plus4_q, pc_plus4_d;
    logic [NB_DATA-1:0]  rs_data_q, rs_data_d;
    logic [NB_DATA-1:0]  rt_data_q, rt_data_d;
    logic [NB_DATA-1:0]  imm_ext_q, imm_ext_d;
    logic [NB_REG-1:0]   rs_q, rs_d;
    logic [NB_REG-1:0]   rt_q, rt_d;
    logic [NB_REG-1:0]   rd_q, rd_d;
    logic [NB_CTRL-1:0]  ctrl_q, ctrl_d;
    logic                valid_q, valid_d;
    logic [NB_COUNT-1:0] stall_count_q, stall_count_d;
    logic                hazard;

    // Load-use hazard: the load in EX writes a register that the ID
    // instruction reads. Register 0 is never a real dependency.
    always_comb begin
        hazard = valid_q && ctrl_q[CTRL_MEM_READ] && (rt_q != '0) && i_valid &&
                 ((rt_q == i_rs) || (rt_q == i_rt));
    end

    // Next-state selection: freeze, bubble (flush or stall) or normal load.
    always_comb begin
        pc_plus4_d    = pc_plus4_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_ext_d     = imm_ext_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        ctrl_d        = ctrl_q;
        valid_d       = valid_q;
        stall_count_d = stall_count_q;
        if (i_enable) begin
            // The data and address fields follow the ID stage even for a
            // bubble. Only ctrl and valid mark the slot as empty.
            pc_plus4_d = i_pc_plus4;
            rs_data_d  = i_rs_data;
            rt_data_d  = i_rt_data;
            imm_ext_d  = i_imm_ext;
            rs_d       = i_rs;
            rt_d       = i_rt;
            rd_d       = i_rd;
            if (i_flush || hazard) begin
                ctrl_d  = '0;
                valid_d = 1'b0;
                // A flush already discards the instruction, so a
                // simultaneous hazard does not count as a stall bubble.
                if (!i_flush && (stall_count_q != {NB_COUNT{1'b1}})) begin
                    stall_count_d = stall_count_q + 1'b1;
                end
            end else begin
                ctrl_d  = i_valid ? i_ctrl : '0;
                valid_d = i_valid;
            end
        end
    end

    // Pipeline state register with asynchronous clear.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc_plus4_q    <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_ext_q     <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            ctrl_q        <= '0;
            valid_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            pc_plus4_q    <= pc_plus4_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_ext_q     <= imm_ext_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            ctrl_q        <= ctrl_d;
            valid_q       <= valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_pc_plus4    = pc_plus4_q;
    assign o_rs_data     = rs_data_q;
    assign o_rt_data     = rt_data_q;
    assign o_imm_ext     = imm_ext_q;
    assign o_rs          = rs_q;
    assign o_rt          = rt_q;
    assign o_rd          = rd_q;
    assign o_ctrl        = ctrl_q;
    assign o_valid       = valid_q;
    assign o_stall       = hazard;
    assign o_stall_count = stall_count_q;

endmodule
